sram_array_ctrl: RTL and testbench
==================================

# sram_array_ctrl

Controller sitting directly upstream of the 512x77 1R1W array macro. Sweeps every entry to zero after reset, then accepts ready/valid read and write requests and drives the macro's read and write ports. Resolves same-address read/write conflicts by stalling the read, and holds read data stable between reads. This is the holdRead plus resetInit behaviour the macro itself lacks.

## Interface
Parameters:
- DEPTH, 512, number of entries; must be a power of two.
- WIDTH, 77, data bits per entry.
- ADDR_W, 9, log2(DEPTH).

Ports:
- clock  in  1  sole clock; also drives the macro's R0_clk and W0_clk.
- reset  in  1  asynchronous, active-high.
- rd_req_valid  in  1  read request.
- rd_req_ready  out  1  read accepted when valid and ready.
- rd_req_addr  in  ADDR_W  read address.
- rd_resp_valid  out  1  one-cycle pulse: read data is available.
- rd_data  out  WIDTH  read data, held until the next response.
- wr_req_valid  in  1  write request.
- wr_req_ready  out  1  write accepted when valid and ready.
- wr_req_addr  in  ADDR_W  write address.
- wr_req_data  in  WIDTH  write data.
- init_done  out  1  high once the zero sweep has completed.
- arr_ren  out  1  macro R0_en.
- arr_raddr  out  ADDR_W  macro R0_addr.
- arr_rdata  in  WIDTH  macro R0_data; valid the cycle after arr_ren.
- arr_wen  out  1  macro W0_en.
- arr_waddr  out  ADDR_W  macro W0_addr.
- arr_wdata  out  WIDTH  macro W0_data.
- arr_wmask  out  1  macro W0_mask; always 1.

## Operation
FSM states: INIT, IDLE.

INIT (entered on reset):
- Counter init_cnt runs from 0 to DEPTH-1.
- Each cycle: arr_wen=1, arr_waddr=init_cnt, arr_wdata=0.
- rd_req_ready=0, wr_req_ready=0, arr_ren=0.
- When init_cnt==DEPTH-1, go to IDLE next cycle and set init_done=1, registered.
- The counter does not wrap; it is ADDR_W bits wide and stops at DEPTH-1.

IDLE:
- wr_req_ready=1 always.
- Accepted write: arr_wen=1, arr_waddr=wr_req_addr, arr_wdata=wr_req_data, all combinational in the same cycle.
- rd_req_ready=1, except when wr_req_valid is high and wr_req_addr==rd_req_addr. The write wins; the read stalls one cycle and is retried when the write drops or the address differs.
- Accepted read: arr_ren=1, arr_raddr=rd_req_addr, combinational.
- Read and write to different addresses in the same cycle are both accepted.

Read data path:
- resp_pending register is set to 1 when a read is accepted.
- While resp_pending=1: rd_resp_valid=1 and rd_data=arr_rdata; hold_q captures arr_rdata at that cycle's edge.
- Otherwise rd_data=hold_q, stable regardless of macro activity.

Reset values:
- state=INIT, init_cnt=0, init_done=0, resp_pending=0, hold_q=0.
- rd_resp_valid=0, rd_data=0, rd_req_ready=0, wr_req_ready=0, arr_ren=0.
- arr_wen=1, arr_waddr=0, arr_wdata=0 (INIT sweep starts immediately).

Reset mid-operation:
- Asynchronous return to INIT with init_cnt=0.
- Any pending response is dropped (no rd_resp_valid pulse).
- The sweep restarts from entry 0.

## Timing
- Sweep: arr_wen is high for exactly DEPTH cycles after reset deassertion; init_done rises on cycle DEPTH.
- Read latency: request accepted in cycle t; rd_resp_valid=1 and data correct in cycle t+1.
- Back-to-back reads: one per cycle, full throughput.
- Write visibility: a write accepted in cycle t is visible to a read accepted in cycle t+1 or later.
- Ready signals are combinational from state and the request inputs. There is no valid-to-valid combinational path.

## Structure
- Shared package: sram_ctrl_state_e with INIT and IDLE; default DEPTH/WIDTH constants.
- Single module. The hold register and FSM are small enough that no sub-module is needed.

## Test plan
- Reset release: arr_wen is high for 512 cycles covering addresses 0..511 with data 0. init_done rises at cycle 512. Both readies stay 0 until then.
- Write 0x1_2345_6789_ABCD_EF01 to addr 5, then read addr 5 the next cycle -> rd_resp_valid one cycle later with exactly that value. Reading addr 6 returns 0.
- Same-cycle read and write to addr 9 -> rd_req_ready=0 and the write is accepted. Next cycle the read is accepted and returns the new data.
- Same-cycle read addr 3 and write addr 4 -> both accepted. The read returns the prior contents of addr 3.
- Read addr 5, then idle 10 cycles while writing addr 5 -> rd_data stays the old value and rd_resp_valid pulses only once.
- Assert reset at sweep cycle 200 and again while a read response is pending -> the sweep restarts at addr 0, no response pulse appears, and init_done stays 0 for a further 512 cycles.

Source files
------------

// File: rtl/sram_array_ctrl_pkg.sv
// Shared types and default geometry for the SRAM array controller.
// Matches the 512x77 1R1W macro it fronts.
package sram_array_ctrl_pkg;

  localparam int unsigned DefDepth = 512;
  localparam int unsigned DefWidth = 77;

  typedef enum logic [0:0] {
    StInit,
    StIdle
  } sram_ctrl_state_e;

endpackage

// File: rtl/sram_array_ctrl.sv
// Front end for a 1R1W SRAM macro: zero-sweeps the array after reset, arbitrates
// ready/valid read/write requests and holds read data between responses.
module sram_array_ctrl
  import sram_array_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [WIDTH-1:0]  wr_req_data,
  output logic              init_done,
  output logic              arr_ren,
  output logic [ADDR_W-1:0] arr_raddr,
  input  logic [WIDTH-1:0]  arr_rdata,
  output logic              arr_wen,
  output logic [ADDR_W-1:0] arr_waddr,
  output logic [WIDTH-1:0]  arr_wdata,
  output logic              arr_wmask
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  sram_ctrl_state_e  state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic              resp_pending_q;
  logic [WIDTH-1:0]  hold_q;
  logic              rd_fire;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    init_done_d  = init_done_q;
    rd_req_ready = 1'b0;
    wr_req_ready = 1'b0;
    rd_fire      = 1'b0;
    arr_ren      = 1'b0;
    arr_raddr    = rd_req_addr;
    arr_wen      = 1'b0;
    arr_waddr    = wr_req_addr;
    arr_wdata    = wr_req_data;

    unique case (state_q)
      StInit: begin
        arr_wen   = 1'b1;
        arr_waddr = init_cnt_q;
        arr_wdata = '0;
        if (init_cnt_q == LastAddr) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_W'(1);
        end
      end
      StIdle: begin
        wr_req_ready = 1'b1;
        // Same-address conflict: the write wins, the read retries next cycle.
        rd_req_ready = !(wr_req_valid && (wr_req_addr == rd_req_addr));
        rd_fire      = rd_req_valid && rd_req_ready;
        arr_ren      = rd_fire;
        arr_wen      = wr_req_valid;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StInit;
      init_cnt_q     <= '0;
      init_done_q    <= 1'b0;
      resp_pending_q <= 1'b0;
      hold_q         <= '0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      init_done_q    <= init_done_d;
      resp_pending_q <= rd_fire;
      if (resp_pending_q) begin
        hold_q <= arr_rdata;
      end
    end
  end

  assign init_done     = init_done_q;
  assign rd_resp_valid = resp_pending_q;
  // Macro output is only trustworthy the cycle after a read; otherwise replay the last one.
  assign rd_data       = resp_pending_q ? arr_rdata : hold_q;
  assign arr_wmask     = 1'b1;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Self-checking bench for sram_array_ctrl with a behavioural macro and a
// memory/response reference model driven by directed and random traffic.
module tb_sram_array_ctrl;

  localparam int unsigned Depth = 512;
  localparam int unsigned Width = 77;
  localparam int unsigned AddrW = 9;

  logic             clock;
  logic             reset;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [AddrW-1:0] rd_req_addr;
  logic             rd_resp_valid;
  logic [Width-1:0] rd_data;
  logic             wr_req_valid;
  logic             wr_req_ready;
  logic [AddrW-1:0] wr_req_addr;
  logic [Width-1:0] wr_req_data;
  logic             init_done;
  logic             arr_ren;
  logic [AddrW-1:0] arr_raddr;
  logic [Width-1:0] arr_rdata;
  logic             arr_wen;
  logic [AddrW-1:0] arr_waddr;
  logic [Width-1:0] arr_wdata;
  logic             arr_wmask;

  sram_array_ctrl #(
    .DEPTH (Depth),
    .WIDTH (Width),
    .ADDR_W(AddrW)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_data      (rd_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .init_done    (init_done),
    .arr_ren      (arr_ren),
    .arr_raddr    (arr_raddr),
    .arr_rdata    (arr_rdata),
    .arr_wen      (arr_wen),
    .arr_waddr    (arr_waddr),
    .arr_wdata    (arr_wdata),
    .arr_wmask    (arr_wmask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [Width-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[Width-1:0];
  endfunction

  // Behavioural 1R1W macro; scramble fills it with garbage so the sweep is observable.
  logic             scramble;
  logic [Width-1:0] macro_mem[Depth];
  logic [Width-1:0] macro_rdata;
  assign arr_rdata = macro_rdata;

  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < Depth; i++) macro_mem[i] <= rand_word();
    end else if (arr_wen && arr_wmask) begin
      macro_mem[arr_waddr] <= arr_wdata;
    end
    if (arr_ren) macro_rdata <= macro_mem[arr_raddr];
  end

  // Reference model: contents of the array and the response expected next cycle.
  logic [Width-1:0] ref_mem[Depth];
  logic             exp_valid;
  logic [Width-1:0] exp_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
    exp_valid = 1'b0;
    exp_data  = '0;
  endtask

  // Called at a falling edge; checks `upto` sweep cycles with hostile request inputs.
  task automatic sweep(input int upto);
    for (int k = 0; k < upto; k++) begin
      rd_req_valid = 1'b1;
      rd_req_addr  = AddrW'($urandom_range(0, Depth - 1));
      wr_req_valid = 1'b1;
      wr_req_addr  = AddrW'($urandom_range(0, Depth - 1));
      wr_req_data  = rand_word();
      #1;
      check_eq("sweep_wen", arr_wen, 1'b1);
      check_eq("sweep_waddr", arr_waddr, k);
      check_eq("sweep_wdata", arr_wdata, '0);
      check_eq("sweep_rd_ready", rd_req_ready, 1'b0);
      check_eq("sweep_wr_ready", wr_req_ready, 1'b0);
      check_eq("sweep_ren", arr_ren, 1'b0);
      check_eq("sweep_init_done", init_done, 1'b0);
      check_eq("sweep_resp_valid", rd_resp_valid, 1'b0);
      @(negedge clock);
    end
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    if (upto == Depth) begin
      #1;
      check_eq("init_done_rise", init_done, 1'b1);
      check_eq("idle_rd_ready", rd_req_ready, 1'b1);
      check_eq("idle_wr_ready", wr_req_ready, 1'b1);
      check_eq("idle_wen", arr_wen, 1'b0);
      check_eq("idle_wmask", arr_wmask, 1'b1);
      @(negedge clock);
      model_reset();
    end
  endtask

  // One IDLE cycle: drive at the falling edge, check outputs, advance the model.
  task automatic step(input logic rv, input logic [AddrW-1:0] ra, input logic wv,
                      input logic [AddrW-1:0] wa, input logic [Width-1:0] wd);
    logic exp_rdy;
    rd_req_valid = rv;
    rd_req_addr  = ra;
    wr_req_valid = wv;
    wr_req_addr  = wa;
    wr_req_data  = wd;
    #1;
    exp_rdy = !(wv && (wa == ra));
    check_eq("resp_valid", rd_resp_valid, exp_valid);
    check_eq("rd_data", rd_data, exp_data);
    check_eq("rd_ready", rd_req_ready, exp_rdy);
    check_eq("wr_ready", wr_req_ready, 1'b1);
    check_eq("arr_wen", arr_wen, wv);
    check_eq("arr_ren", arr_ren, rv && exp_rdy);
    if (wv) begin
      check_eq("arr_waddr", arr_waddr, wa);
      check_eq("arr_wdata", arr_wdata, wd);
    end
    if (rv && exp_rdy) check_eq("arr_raddr", arr_raddr, ra);
    if (rv && exp_rdy) begin
      exp_valid = 1'b1;
      exp_data  = ref_mem[ra];
    end else begin
      exp_valid = 1'b0;
    end
    if (wv) ref_mem[wa] = wd;
    @(negedge clock);
  endtask

  initial begin
    logic [Width-1:0] pat;
    pat          = 77'h1_2345_6789_ABCD_EF01;
    reset        = 1'b1;
    scramble     = 1'b1;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    wr_req_valid = 1'b0;
    wr_req_addr  = '0;
    wr_req_data  = '0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    scramble = 1'b0;
    #1;
    check_eq("rst_wen", arr_wen, 1'b1);
    check_eq("rst_waddr", arr_waddr, '0);
    check_eq("rst_wdata", arr_wdata, '0);
    check_eq("rst_rd_data", rd_data, '0);
    check_eq("rst_init_done", init_done, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Interrupt the sweep at cycle 200, then run it fully.
    sweep(200);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_waddr", arr_waddr, '0);
    check_eq("midrst_init_done", init_done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    sweep(Depth);

    // Directed: write then read, read of untouched entry.
    step(1'b0, 9'd0, 1'b1, 9'd5, pat);
    step(1'b1, 9'd5, 1'b0, 9'd0, '0);
    #1 check_eq("rd5_value", rd_data, pat);
    step(1'b1, 9'd6, 1'b0, 9'd0, '0);
    #1 check_eq("rd6_zero", rd_data, '0);
    // Same-address conflict, then retry.
    step(1'b1, 9'd9, 1'b1, 9'd9, rand_word());
    step(1'b1, 9'd9, 1'b0, 9'd0, '0);
    // Different addresses in one cycle.
    step(1'b1, 9'd3, 1'b1, 9'd4, rand_word());
    step(1'b1, 9'd4, 1'b0, 9'd0, '0);
    // Hold: read addr 5 then keep overwriting it with no reads.
    step(1'b1, 9'd5, 1'b0, 9'd0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 9'd5, 1'b1, 9'd5, rand_word());
    #1 check_eq("hold_value", rd_data, pat);

    // Random traffic over a narrow window to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 6), AddrW'($urandom_range(0, 15)),
           1'($urandom_range(0, 9) < 5), AddrW'($urandom_range(0, 15)), rand_word());
    end

    // Reset while a response is pending.
    step(1'b1, 9'd7, 1'b0, 9'd0, '0);
    #2 reset = 1'b1;
    #1;
    check_eq("pend_rst_resp", rd_resp_valid, 1'b0);
    check_eq("pend_rst_data", rd_data, '0);
    @(negedge clock);
    reset = 1'b0;
    sweep(Depth);

    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), AddrW'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), AddrW'($urandom_range(0, 7)), rand_word());
    end
    step(1'b0, 9'd0, 1'b0, 9'd0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
